// File: rtl/rx_lock_ctrl.sv
// Block-lock controller for a 64b/66b receiver: commits a stable header offset
// from the seeker, verifies it against incoming sync headers, and monitors lock.
module rx_lock_ctrl #(
  parameter int unsigned STABLE_CNT  = 16,
  parameter int unsigned GOOD_HDR    = 64,
  parameter int unsigned BAD_HDR_MAX = 16,
  parameter int unsigned WINDOW      = 64
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [6:0] seek_offset_i,
  input  logic       seek_dv_i,
  input  logic [1:0] hdr_i,
  input  logic       hdr_dv_i,
  input  logic       force_resync_i,
  output logic [6:0] offset_o,
  output logic       offset_load_o,
  output logic       locked_o,
  output logic [1:0] state_o,
  output logic [7:0] relock_cnt_o
);

  typedef enum logic [1:0] {
    S_SEARCH = 2'b00,
    S_VERIFY = 2'b01,
    S_LOCKED = 2'b10,
    S_RESYNC = 2'b11
  } state_t;

  state_t     state_q, state_d;
  logic [6:0] cand_q, cand_d;
  logic [6:0] offset_q, offset_d;
  logic       load_q, load_d;
  logic [7:0] stable_q, stable_d;
  logic [7:0] good_q, good_d;
  logic [7:0] win_q, win_d;
  logic [7:0] bad_q, bad_d;
  logic [7:0] relock_q, relock_d;
  logic       hdr_valid;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign hdr_valid = (hdr_i == 2'b01) || (hdr_i == 2'b10);

  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    offset_d = offset_q;
    load_d   = 1'b0;
    stable_d = stable_q;
    good_d   = good_q;
    win_d    = win_q;
    bad_d    = bad_q;
    relock_d = relock_q;

    case (state_q)
      S_SEARCH: begin
        if (seek_dv_i) begin
          if (seek_offset_i <= 7'd65) begin
            if (seek_offset_i == cand_q) begin
              stable_d = sat_inc(stable_q);
            end else begin
              cand_d   = seek_offset_i;
              stable_d = 8'd1;
            end
            if (stable_d == 8'(STABLE_CNT)) begin
              offset_d = cand_d;
              load_d   = 1'b1;
              state_d  = S_VERIFY;
              stable_d = '0;
              good_d   = '0;
              win_d    = '0;
              bad_d    = '0;
            end
          end else begin
            stable_d = '0;
          end
        end
      end
      S_VERIFY: begin
        // load_q is high only in the first VERIFY cycle, so it masks that header
        if (hdr_dv_i && !load_q) begin
          if (hdr_valid) begin
            good_d = sat_inc(good_q);
            if (good_d == 8'(GOOD_HDR)) state_d = S_LOCKED;
          end else begin
            state_d  = S_SEARCH;
            cand_d   = '0;
            stable_d = '0;
            good_d   = '0;
            win_d    = '0;
            bad_d    = '0;
          end
        end
      end
      S_LOCKED: begin
        if (hdr_dv_i) begin
          win_d = sat_inc(win_q);
          if (!hdr_valid) bad_d = sat_inc(bad_q);
          if (bad_d == 8'(BAD_HDR_MAX)) begin
            state_d = S_RESYNC;
          end else if (win_d == 8'(WINDOW)) begin
            win_d = '0;
            bad_d = '0;
          end
        end
      end
      S_RESYNC: state_d = S_SEARCH;
      default:  state_d = S_SEARCH;
    endcase

    // Forced resync also cancels a commit decided in the same cycle
    if (force_resync_i && state_q != S_RESYNC) begin
      state_d  = S_RESYNC;
      offset_d = offset_q;
      load_d   = 1'b0;
    end

    if (state_d == S_RESYNC && state_q != S_RESYNC) begin
      relock_d = sat_inc(relock_q);
      cand_d   = '0;
      stable_d = '0;
      good_d   = '0;
      win_d    = '0;
      bad_d    = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_SEARCH;
      cand_q   <= '0;
      offset_q <= '0;
      load_q   <= 1'b0;
      stable_q <= '0;
      good_q   <= '0;
      win_q    <= '0;
      bad_q    <= '0;
      relock_q <= '0;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      offset_q <= offset_d;
      load_q   <= load_d;
      stable_q <= stable_d;
      good_q   <= good_d;
      win_q    <= win_d;
      bad_q    <= bad_d;
      relock_q <= relock_d;
    end
  end

  assign offset_o      = offset_q;
  assign offset_load_o = load_q;
  assign locked_o      = (state_q == S_LOCKED);
  assign state_o       = state_q;
  assign relock_cnt_o  = relock_q;

endmodule

// File: tb/tb_rx_lock_ctrl.sv
// Directed bench for rx_lock_ctrl: expectations queued with each stimulus step
// and checked against the DUT outputs one cycle later.
module tb_rx_lock_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] seek_offset;
  logic       seek_dv;
  logic [1:0] hdr;
  logic       hdr_dv;
  logic       force_resync;
  logic [6:0] offset;
  logic       offset_load;
  logic       locked;
  logic [1:0] state;
  logic [7:0] relock_cnt;

  typedef enum int {K_STATE, K_OFFSET, K_LOAD, K_LOCKED, K_RELOCK} kind_t;
  typedef struct {
    string      tag;
    kind_t      kind;
    logic [7:0] exp;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  rx_lock_ctrl #(
    .STABLE_CNT (4),
    .GOOD_HDR   (8),
    .BAD_HDR_MAX(4),
    .WINDOW     (16)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .seek_offset_i (seek_offset),
    .seek_dv_i     (seek_dv),
    .hdr_i         (hdr),
    .hdr_dv_i      (hdr_dv),
    .force_resync_i(force_resync),
    .offset_o      (offset),
    .offset_load_o (offset_load),
    .locked_o      (locked),
    .state_o       (state),
    .relock_cnt_o  (relock_cnt)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic seek(input logic [6:0] o);
    seek_offset = o;
    seek_dv     = 1'b1;
    cyc();
    seek_dv     = 1'b0;
  endtask

  task automatic hdrs(input logic [1:0] h, input int n);
    for (int i = 0; i < n; i++) begin
      hdr    = h;
      hdr_dv = 1'b1;
      cyc();
      hdr_dv = 1'b0;
    end
  endtask

  task automatic valid_hdrs(input int n);
    for (int i = 0; i < n; i++) hdrs((i % 2 == 0) ? 2'b01 : 2'b10, 1);
  endtask

  task automatic push(input string tag, input kind_t k, input logic [7:0] e);
    exp_t x;
    x.tag = tag; x.kind = k; x.exp = e;
    q.push_back(x);
  endtask

  task automatic check();
    exp_t       x;
    logic [7:0] obs;
    while (q.size() > 0) begin
      x = q.pop_front();
      case (x.kind)
        K_STATE:  obs = {6'd0, state};
        K_OFFSET: obs = {1'b0, offset};
        K_LOAD:   obs = {7'd0, offset_load};
        K_LOCKED: obs = {7'd0, locked};
        default:  obs = relock_cnt;
      endcase
      tests++;
      assert (obs === x.exp) else begin
        fails++;
        $error("FAIL %s: observed %0d expected %0d", x.tag, obs, x.exp);
      end
    end
  endtask

  initial begin
    rst = 1'b1; seek_offset = '0; seek_dv = 1'b0; hdr = '0; hdr_dv = 1'b0;
    force_resync = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    push("rst_state", K_STATE, 8'd0);
    push("rst_offset", K_OFFSET, 8'd0);
    push("rst_load", K_LOAD, 8'd0);
    push("rst_locked", K_LOCKED, 8'd0);
    push("rst_relock", K_RELOCK, 8'd0);
    check();

    // Basic commit and lock
    seek(7'd23); seek(7'd23); seek(7'd23);
    push("pre_commit_state", K_STATE, 8'd0);
    push("pre_commit_load", K_LOAD, 8'd0);
    check();
    seek(7'd23);
    push("commit_state", K_STATE, 8'd1);
    push("commit_offset", K_OFFSET, 8'd23);
    push("commit_load", K_LOAD, 8'd1);
    check();
    cyc();
    push("load_one_shot", K_LOAD, 8'd0);
    check();
    valid_hdrs(7);
    push("verify7_state", K_STATE, 8'd1);
    push("verify7_locked", K_LOCKED, 8'd0);
    check();
    valid_hdrs(1);
    push("lock_state", K_STATE, 8'd2);
    push("lock_locked", K_LOCKED, 8'd1);
    check();

    // Three bad headers per window over three windows keeps lock
    for (int w = 0; w < 3; w++) begin
      hdrs(2'b00, 1); hdrs(2'b11, 1); hdrs(2'b00, 1);
      valid_hdrs(13);
      push("window_hold", K_LOCKED, 8'd1);
      check();
    end
    hdrs(2'b11, 3);
    push("bad3_locked", K_LOCKED, 8'd1);
    check();
    hdrs(2'b00, 1);
    push("drop_state", K_STATE, 8'd3);
    push("drop_locked", K_LOCKED, 8'd0);
    push("drop_relock", K_RELOCK, 8'd1);
    check();
    cyc();
    push("resync_exit", K_STATE, 8'd0);
    check();

    // Candidate change restarts the stable count
    seek(7'd23); seek(7'd23); seek(7'd40); seek(7'd40); seek(7'd40);
    push("five_strobes_state", K_STATE, 8'd0);
    push("five_strobes_offset", K_OFFSET, 8'd23);
    check();
    seek(7'd40);
    push("sixth_state", K_STATE, 8'd1);
    push("sixth_offset", K_OFFSET, 8'd40);
    check();

    // Invalid header in the entry cycle is ignored; later one aborts
    hdrs(2'b11, 1);
    push("entry_ignored", K_STATE, 8'd1);
    check();
    valid_hdrs(5);
    hdrs(2'b11, 1);
    push("verify_fail_state", K_STATE, 8'd0);
    push("verify_fail_locked", K_LOCKED, 8'd0);
    push("verify_fail_relock", K_RELOCK, 8'd1);
    check();

    // Out-of-range offset clears the stable count
    seek(7'd55); seek(7'd55); seek(7'd55); seek(7'd70);
    seek(7'd55); seek(7'd55); seek(7'd55);
    push("oor_restart_state", K_STATE, 8'd0);
    push("oor_restart_offset", K_OFFSET, 8'd40);
    check();
    seek(7'd55);
    push("oor_commit_offset", K_OFFSET, 8'd55);
    push("oor_commit_state", K_STATE, 8'd1);
    check();

    // Seeker strobes ignored in VERIFY, including alongside headers
    seek(7'd10); seek(7'd10); seek(7'd10); seek(7'd10);
    push("seek_ignored_offset", K_OFFSET, 8'd55);
    push("seek_ignored_load", K_LOAD, 8'd0);
    check();
    seek_offset = 7'd10; seek_dv = 1'b1;
    valid_hdrs(8);
    seek_dv = 1'b0;
    push("relock_state", K_STATE, 8'd2);
    push("relock_offset", K_OFFSET, 8'd55);
    check();

    // Fourth bad header as the sixteenth of the window still drops
    valid_hdrs(12);
    hdrs(2'b00, 3);
    push("edge15_state", K_STATE, 8'd2);
    check();
    hdrs(2'b11, 1);
    push("edge_drop_state", K_STATE, 8'd3);
    push("edge_drop_relock", K_RELOCK, 8'd2);
    check();
    cyc();

    // Force held across RESYNC counts only once
    force_resync = 1'b1;
    cyc();
    push("force_state", K_STATE, 8'd3);
    check();
    cyc();
    force_resync = 1'b0;
    push("force_in_resync", K_STATE, 8'd0);
    push("force_relock", K_RELOCK, 8'd3);
    check();

    for (int i = 0; i < 300; i++) begin
      force_resync = 1'b1; cyc();
      force_resync = 1'b0; cyc();
    end
    push("relock_sat", K_RELOCK, 8'd255);
    push("sat_state", K_STATE, 8'd0);
    check();

    // Reset beats force_resync mid-VERIFY
    seek(7'd30); seek(7'd30); seek(7'd30); seek(7'd30);
    valid_hdrs(3);
    push("pre_rst_state", K_STATE, 8'd1);
    check();
    rst = 1'b1; force_resync = 1'b1;
    cyc();
    rst = 1'b0; force_resync = 1'b0;
    push("rst2_state", K_STATE, 8'd0);
    push("rst2_offset", K_OFFSET, 8'd0);
    push("rst2_load", K_LOAD, 8'd0);
    push("rst2_locked", K_LOCKED, 8'd0);
    push("rst2_relock", K_RELOCK, 8'd0);
    check();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
